axil_lfsr_mc: RTL

- Multi-channel successor to the single-channel AXI-Lite LFSR generator.
- NUM_CH independent Fibonacci LFSRs of width DATA_W, each with its own seed, taps, burst count and start/stop control, all programmed over one AXI4-Lite slave.
- Outputs are round-robin merged onto one AXI-Stream master, tagged with the channel id on tuser and with tlast marking the end of a burst.
- Sits between the CPU AXI-Lite interconnect and stream consumers: DMA, scramblers, test pattern sinks.

---
 rtl/axil_lfsr_pkg.sv | 37 +++
 rtl/axil_lfsr_mc_channel.sv | 79 +++++++
 rtl/axil_lfsr_mc.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/axil_lfsr_pkg.sv
// Shared definitions for the multi-channel AXI-Lite LFSR generator.
// Holds register offsets, CTRL/STATUS bit positions, AXI response codes,
// the per-channel FSM encodings and the channel-id width helper.
package axil_lfsr_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_SLVERR = 2'b10;

  // Global registers
  localparam int OFF_CTRL   = 'h00;
  localparam int OFF_STATUS = 'h04;

  // Per-channel register block: base + stride * channel + offset
  localparam int CH_BASE       = 'h10;
  localparam int CH_STRIDE     = 'h10;
  localparam int CH_SEED_OFF   = 'h0;
  localparam int CH_TAPS_OFF   = 'h4;
  localparam int CH_COUNT_OFF  = 'h8;
  localparam int CH_STATE_OFF  = 'hC;

  // CTRL carries start pulses in the low half and stop pulses in the high half
  localparam int CTRL_START_LSB  = 0;
  localparam int CTRL_STOP_LSB   = 16;
  localparam int STATUS_SLOT_BIT = 31;

  // Channel FSM encodings
  localparam logic [0:0] CH_IDLE = 1'b0;
  localparam logic [0:0] CH_RUN  = 1'b1;

  // Channel id width, never narrower than one bit
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axil_lfsr_mc_channel.sv
// One Fibonacci LFSR channel: programmable seed/taps/count, IDLE/RUN FSM.
// Ports:
//   aclk, areset            clock, asynchronous active-high reset
//   wdata                   register write data (shared by all channels)
//   seed_we/taps_we/count_we register write strobes for this channel
//   start, stop             control pulses (stop has priority)
//   grant                   this channel's beat is being loaded into the slot
//   req                     channel is running and wants a slot
//   data, last              current LFSR word and end-of-burst flag
//   seed, taps, count       register readback
module lfsr_channel
  import axil_lfsr_pkg::*;
#(
  parameter int DATA_W = 32
)(
  input  logic              aclk,
  input  logic              areset,
  input  logic [31:0]       wdata,
  input  logic              seed_we,
  input  logic              taps_we,
  input  logic              count_we,
  input  logic              start,
  input  logic              stop,
  input  logic              grant,
  output logic              req,
  output logic [DATA_W-1:0] data,
  output logic              last,
  output logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] taps,
  output logic [31:0]       count
);

  logic [DATA_W-1:0] seed_reg;
  logic [DATA_W-1:0] taps_reg;
  logic [DATA_W-1:0] lfsr_reg;
  logic [DATA_W-1:0] lfsr_next;
  logic [31:0]       count_reg;
  logic [31:0]       remain_reg;
  logic [0:0]        fsm_reg;

  assign lfsr_next = {lfsr_reg[DATA_W-2:0], ^(lfsr_reg & taps_reg)};

  assign req   = (fsm_reg == CH_RUN);
  assign data  = lfsr_reg;
  // remain==0 means continuous, so only a counted run can flag last
  assign last  = (remain_reg == 32'd1);
  assign seed  = seed_reg;
  assign taps  = taps_reg;
  assign count = count_reg;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      seed_reg   <= '0;
      taps_reg   <= '0;
      count_reg  <= '0;
      lfsr_reg   <= '0;
      remain_reg <= '0;
      fsm_reg    <= CH_IDLE;
    end else begin
      if (seed_we)  seed_reg  <= wdata[DATA_W-1:0];
      if (taps_we)  taps_reg  <= wdata[DATA_W-1:0];
      if (count_we) count_reg <= wdata;

      if (stop) begin
        fsm_reg <= CH_IDLE;
      end else if (start) begin
        // An all-zero state would lock up the LFSR, so a zero seed loads 1
        lfsr_reg   <= (seed_reg == '0) ? DATA_W'(1) : seed_reg;
        remain_reg <= count_reg;
        fsm_reg    <= CH_RUN;
      end else if (grant && fsm_reg == CH_RUN) begin
        lfsr_reg <= lfsr_next;
        if (remain_reg != '0) remain_reg <= remain_reg - 32'd1;
        if (remain_reg == 32'd1) fsm_reg <= CH_IDLE;
      end
    end
  end

endmodule

// File: rtl/axil_lfsr_mc.sv
// Multi-channel AXI-Lite programmable LFSR generator with a round-robin
// merged AXI-Stream output.
// Ports:
//   aclk, areset     clock, asynchronous active-high reset
//   s_axi_*          AXI4-Lite slave (register map in axil_lfsr_pkg)
//   m_axis_tdata     LFSR word
//   m_axis_tvalid/tready stream handshake
//   m_axis_tlast     final beat of a counted burst
//   m_axis_tuser     source channel id
module axil_lfsr_mc
  import axil_lfsr_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int ADDR_W = 8,
  parameter int CH_W   = ch_w(NUM_CH)
)(
  input  logic              aclk,
  input  logic              areset,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [31:0]       s_axi_wdata,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  output logic [1:0]        s_axi_bresp,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  output logic [31:0]       s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic [CH_W-1:0]   m_axis_tuser
);

  // AXI-Lite state
  logic              aw_held_reg, w_held_reg, bvalid_reg, rvalid_reg;
  logic [ADDR_W-1:0] aw_addr_reg;
  logic [31:0]       w_data_reg, rdata_reg;
  axi_resp_t         bresp_reg, rresp_reg;

  // Output slot and arbiter state
  logic              slot_valid_reg, slot_last_reg;
  logic [DATA_W-1:0] slot_data_reg;
  logic [CH_W-1:0]   slot_user_reg, last_grant_reg;

  // Channel interface
  logic [NUM_CH-1:0] ch_req, ch_last, ch_grant, ch_start, ch_stop;
  logic [NUM_CH-1:0] ch_seed_we, ch_taps_we, ch_count_we;
  logic [DATA_W-1:0] ch_data [NUM_CH];
  logic [DATA_W-1:0] ch_seed [NUM_CH];
  logic [DATA_W-1:0] ch_taps [NUM_CH];
  logic [31:0]       ch_count [NUM_CH];

  // Write decode on the latched address
  int        wr_a, wr_idx, wr_off;
  logic      wr_ctrl, wr_ch_ok, do_write, do_update;
  // Read decode on the live address, captured at the AR handshake
  int        rd_a, rd_idx, rd_off;
  logic [31:0] rd_data;
  axi_resp_t rd_resp;
  // Arbiter
  int              arb_idx;
  logic            grant_any, load;
  logic [CH_W-1:0] grant_idx;

  assign s_axi_awready = !aw_held_reg && !bvalid_reg;
  assign s_axi_wready  = !w_held_reg && !bvalid_reg;
  assign s_axi_bvalid  = bvalid_reg;
  assign s_axi_bresp   = bresp_reg;
  assign s_axi_arready = !rvalid_reg;
  assign s_axi_rvalid  = rvalid_reg;
  assign s_axi_rdata   = rdata_reg;
  assign s_axi_rresp   = rresp_reg;

  assign m_axis_tvalid = slot_valid_reg;
  assign m_axis_tdata  = slot_data_reg;
  assign m_axis_tuser  = slot_user_reg;
  assign m_axis_tlast  = slot_last_reg;

  always_comb begin
    wr_a     = int'(aw_addr_reg);
    wr_idx   = (wr_a - CH_BASE) / CH_STRIDE;
    wr_off   = wr_a % CH_STRIDE;
    wr_ctrl  = (wr_a == OFF_CTRL);
    // STATE is read-only, so only SEED/TAPS/COUNT are writable per channel
    wr_ch_ok = (wr_a >= CH_BASE) && (wr_a < CH_BASE + CH_STRIDE * NUM_CH) &&
               (wr_off == CH_SEED_OFF || wr_off == CH_TAPS_OFF || wr_off == CH_COUNT_OFF);
  end

  assign do_write  = aw_held_reg && w_held_reg;
  assign do_update = do_write && (wr_ctrl || wr_ch_ok);

  always_comb begin
    rd_a    = int'(s_axi_araddr);
    rd_idx  = (rd_a - CH_BASE) / CH_STRIDE;
    rd_off  = rd_a % CH_STRIDE;
    rd_data = '0;
    rd_resp = RESP_SLVERR;
    if (rd_a == OFF_CTRL) begin
      rd_resp = RESP_OKAY;
    end else if (rd_a == OFF_STATUS) begin
      rd_data[NUM_CH-1:0]     = ch_req;
      rd_data[STATUS_SLOT_BIT] = slot_valid_reg;
      rd_resp = RESP_OKAY;
    end else if (rd_a >= CH_BASE && rd_a < CH_BASE + CH_STRIDE * NUM_CH) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (rd_idx == c) begin
          case (rd_off)
            CH_SEED_OFF:  begin rd_data[DATA_W-1:0] = ch_seed[c]; rd_resp = RESP_OKAY; end
            CH_TAPS_OFF:  begin rd_data[DATA_W-1:0] = ch_taps[c]; rd_resp = RESP_OKAY; end
            CH_COUNT_OFF: begin rd_data = ch_count[c];            rd_resp = RESP_OKAY; end
            CH_STATE_OFF: begin rd_data[DATA_W-1:0] = ch_data[c]; rd_resp = RESP_OKAY; end
            default: ;
          endcase
        end
      end
    end
  end

  // Round-robin: scan starting one past the last granted channel
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    arb_idx   = 0;
    for (int i = 1; i <= NUM_CH; i++) begin
      arb_idx = (int'(last_grant_reg) + i) % NUM_CH;
      if (!grant_any && ch_req[arb_idx]) begin
        grant_any = 1'b1;
        grant_idx = CH_W'(arb_idx);
      end
    end
  end

  // Slot refills in the same cycle it drains, sustaining one beat per cycle
  assign load = grant_any && (!slot_valid_reg || m_axis_tready);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign ch_seed_we[gi]  = do_update && wr_ch_ok && wr_idx == gi && wr_off == CH_SEED_OFF;
      assign ch_taps_we[gi]  = do_update && wr_ch_ok && wr_idx == gi && wr_off == CH_TAPS_OFF;
      assign ch_count_we[gi] = do_update && wr_ch_ok && wr_idx == gi && wr_off == CH_COUNT_OFF;
      assign ch_start[gi]    = do_update && wr_ctrl && w_data_reg[CTRL_START_LSB + gi];
      assign ch_stop[gi]     = do_update && wr_ctrl && w_data_reg[CTRL_STOP_LSB + gi];
      assign ch_grant[gi]    = load && (grant_idx == CH_W'(gi));

      lfsr_channel #(.DATA_W(DATA_W)) u_ch (
        .aclk     (aclk),
        .areset   (areset),
        .wdata    (w_data_reg),
        .seed_we  (ch_seed_we[gi]),
        .taps_we  (ch_taps_we[gi]),
        .count_we (ch_count_we[gi]),
        .start    (ch_start[gi]),
        .stop     (ch_stop[gi]),
        .grant    (ch_grant[gi]),
        .req      (ch_req[gi]),
        .data     (ch_data[gi]),
        .last     (ch_last[gi]),
        .seed     (ch_seed[gi]),
        .taps     (ch_taps[gi]),
        .count    (ch_count[gi])
      );
    end
  endgenerate

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      aw_held_reg <= 1'b0;
      w_held_reg  <= 1'b0;
      aw_addr_reg <= '0;
      w_data_reg  <= '0;
      bvalid_reg  <= 1'b0;
      bresp_reg   <= RESP_OKAY;
      rvalid_reg  <= 1'b0;
      rdata_reg   <= '0;
      rresp_reg   <= RESP_OKAY;
    end else begin
      if (s_axi_awvalid && s_axi_awready) begin
        aw_held_reg <= 1'b1;
        aw_addr_reg <= s_axi_awaddr;
      end
      if (s_axi_wvalid && s_axi_wready) begin
        w_held_reg <= 1'b1;
        w_data_reg <= s_axi_wdata;
      end
      if (do_write) begin
        aw_held_reg <= 1'b0;
        w_held_reg  <= 1'b0;
        bvalid_reg  <= 1'b1;
        bresp_reg   <= (wr_ctrl || wr_ch_ok) ? RESP_OKAY : RESP_SLVERR;
      end else if (bvalid_reg && s_axi_bready) begin
        bvalid_reg <= 1'b0;
      end
      if (s_axi_arvalid && s_axi_arready) begin
        rvalid_reg <= 1'b1;
        rdata_reg  <= rd_data;
        rresp_reg  <= rd_resp;
      end else if (rvalid_reg && s_axi_rready) begin
        rvalid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      slot_valid_reg <= 1'b0;
      slot_data_reg  <= '0;
      slot_user_reg  <= '0;
      slot_last_reg  <= 1'b0;
      last_grant_reg <= '0;
    end else if (load) begin
      slot_valid_reg <= 1'b1;
      slot_data_reg  <= ch_data[grant_idx];
      slot_user_reg  <= grant_idx;
      slot_last_reg  <= ch_last[grant_idx];
      last_grant_reg <= grant_idx;
    end else if (m_axis_tready) begin
      slot_valid_reg <= 1'b0;
    end
  end

endmodule
